// File: rtl/alu_operand_stage.sv
// alu_operand_stage - issue stage feeding the slot ALU: operand capture, 2-entry op FIFO, RAW/WAW scoreboard
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_in1,
    output logic [DATA_W-1:0] out_in2,
    output logic [REG_AW-1:0] out_rd
);
    localparam int NREG = 1 << REG_AW;
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state, state_nx;
    logic [NREG-1:0]   pend, pend_nx, set_mask, clr_mask;
    logic              push, pop;
    logic              head_ld_new, head_ld_tail, tail_ld;
    logic [DATA_W-1:0] cap_in1, cap_in2;
    logic              rs1_ok, rs2_ok, rd_ok;

    logic [OP_W-1:0]   h_op,  t_op;
    logic [DATA_W-1:0] h_in1, t_in1, h_in2, t_in2;
    logic [REG_AW-1:0] h_rd,  t_rd;

    // A source is usable if hardwired zero, not pending, or being written back right now.
    function automatic logic src_clear(input logic [REG_AW-1:0] s, input logic [NREG-1:0] p,
                                       input logic wbv, input logic [REG_AW-1:0] wbr);
        return (s == '0) || !p[s] || (wbv && (wbr == s));
    endfunction

    function automatic logic [DATA_W-1:0] src_val(input logic [REG_AW-1:0] s,
                                                  input logic [DATA_W-1:0] rdata,
                                                  input logic wbv, input logic [REG_AW-1:0] wbr,
                                                  input logic [DATA_W-1:0] wbd);
        if (s == '0)
            return '0;
        else if (wbv && (wbr == s))
            return wbd;
        else
            return rdata;
    endfunction

    always_comb begin
        rs1_ok   = src_clear(in_rs1, pend, wb_valid, wb_rd);
        rs2_ok   = in_use_imm || src_clear(in_rs2, pend, wb_valid, wb_rd);
        rd_ok    = src_clear(in_rd, pend, wb_valid, wb_rd);
        in_ready = !reset && (state != FULL) && rs1_ok && rs2_ok && rd_ok;
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        cap_in1  = src_val(in_rs1, rf_rdata1, wb_valid, wb_rd, wb_data);
        cap_in2  = in_use_imm ? in_imm : src_val(in_rs2, rf_rdata2, wb_valid, wb_rd, wb_data);
    end

    // Set is applied after clear so a same-cycle set/clear on one register leaves it pending.
    always_comb begin
        clr_mask = wb_valid ? (ONE_HOT0 << wb_rd) : '0;
        set_mask = (push && (in_rd != '0)) ? (ONE_HOT0 << in_rd) : '0;
        pend_nx  = ((pend & ~clr_mask) | set_mask) & ~ONE_HOT0;
    end

    always_comb begin
        state_nx     = state;
        head_ld_new  = 1'b0;
        head_ld_tail = 1'b0;
        tail_ld      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nx    = ONE;
                    head_ld_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_ld_new = 1'b1;
                end else if (push) begin
                    state_nx = FULL;
                    tail_ld  = 1'b1;
                end else if (pop) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nx     = ONE;
                    head_ld_tail = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            pend  <= '0;
            h_op  <= '0;
            h_in1 <= '0;
            h_in2 <= '0;
            h_rd  <= '0;
            t_op  <= '0;
            t_in1 <= '0;
            t_in2 <= '0;
            t_rd  <= '0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            if (head_ld_new) begin
                h_op  <= in_op;
                h_in1 <= cap_in1;
                h_in2 <= cap_in2;
                h_rd  <= in_rd;
            end else if (head_ld_tail) begin
                h_op  <= t_op;
                h_in1 <= t_in1;
                h_in2 <= t_in2;
                h_rd  <= t_rd;
            end
            if (tail_ld) begin
                t_op  <= in_op;
                t_in1 <= cap_in1;
                t_in2 <= cap_in2;
                t_rd  <= in_rd;
            end
        end
    end

    assign out_valid = (state != EMPTY);
    assign out_op    = h_op;
    assign out_in1   = h_in1;
    assign out_in2   = h_in2;
    assign out_rd    = h_rd;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage with directed vectors
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_use_imm;
    logic [1:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm, rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [1:0]  out_op;
    logic [31:0] out_in1, out_in2;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(32), .REG_AW(5), .OP_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_in1(out_in1), .out_in2(out_in2), .out_rd(out_rd)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every consumed head op must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_pop", {out_op, out_in1, out_in2, out_rd}, 72'd0);
                end else begin
                    chk("pop_data", {1'b0, out_op, out_in1, out_in2, out_rd}, {1'b0, q.pop_front()});
                end
            end
        end
    end

    task automatic set_in(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic use_imm, input logic [31:0] imm,
                          input logic [31:0] rf1, input logic [31:0] rf2);
        in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_use_imm = use_imm; in_imm = imm; rf_rdata1 = rf1; rf_rdata2 = rf2;
    endtask

    // Called just after a rising edge; returns after the accepting edge.
    task automatic do_push(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic use_imm, input logic [31:0] imm,
                           input logic [31:0] rf1, input logic [31:0] rf2,
                           input logic [31:0] e1, input logic [31:0] e2, output int waited);
        bit done = 0;
        set_in(op, rs1, rs2, rd, use_imm, imm, rf1, rf2);
        in_valid = 1'b1;
        waited = 0;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{op: op, in1: e1, in2: e2, rd: rd});
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 72'd0, 72'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int w;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        set_in(2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);

        // 1: reset state, then basic capture with latency 1
        idle(2);
        @(negedge clk);
        chk("reset_out_valid", {71'd0, out_valid}, 72'd0);
        chk("reset_out_fields", {out_op, out_in1, out_in2, out_rd}, 72'd0);
        chk("reset_in_ready", {71'd0, in_ready}, 72'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        do_push(2'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 32'd5, 32'd7, 32'd5, 32'd7, w);
        chk("basic_wait", w, 0);
        @(negedge clk);
        chk("latency1_valid", {71'd0, out_valid}, 72'd1);
        @(posedge clk); #1;

        // 2: RAW stall on r3, released by same-cycle writeback with bypass
        set_in(2'd1, 5'd3, 5'd0, 5'd4, 1'b0, 32'd0, 32'hDEAD, 32'h1111);
        in_valid = 1'b1;
        @(negedge clk);
        chk("raw_stall", {71'd0, in_ready}, 72'd0);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
        @(negedge clk);
        chk("raw_bypass_ready", {71'd0, in_ready}, 72'd1);
        q.push_back('{op: 2'd1, in1: 32'd9, in2: 32'd0, rd: 5'd4});
        @(posedge clk); #1;
        in_valid = 1'b0; wb_valid = 1'b0;
        idle(2);

        // 3: fill to FULL, no push while popping from FULL
        out_ready = 1'b0;
        do_push(2'd2, 5'd5, 5'd6, 5'd0, 1'b0, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, w);
        do_push(2'd3, 5'd7, 5'd8, 5'd0, 1'b0, 32'd0, 32'h33, 32'h44, 32'h33, 32'h44, w);
        chk("fill_second_wait", w, 0);
        set_in(2'd0, 5'd9, 5'd10, 5'd0, 1'b0, 32'd0, 32'h55, 32'h66);
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_stall", {71'd0, in_ready}, 72'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_no_push", {71'd0, in_ready}, 72'd0);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("second_head", {38'd0, out_op, out_in1}, {38'd0, 2'd3, 32'h33});
        @(posedge clk); #1;
        do_push(2'd0, 5'd9, 5'd10, 5'd0, 1'b0, 32'd0, 32'h55, 32'h66, 32'h55, 32'h66, w);
        out_ready = 1'b1;
        idle(4);

        // 4: immediate ignores pending rs2 (r4 pending from test 2)
        do_push(2'd1, 5'd1, 5'd4, 5'd0, 1'b1, 32'hFFFF_FFF0, 32'h0F0F_0F0F, 32'h1234,
                32'h0F0F_0F0F, 32'hFFFF_FFF0, w);
        chk("imm_no_stall", w, 0);
        set_in(2'd0, 5'd4, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("r4_still_pending", {71'd0, in_ready}, 72'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // 5: rs1=0 reads zero; rd=0 leaves scoreboard alone
        do_push(2'd3, 5'd0, 5'd2, 5'd0, 1'b0, 32'd0, 32'hABCD, 32'h77, 32'd0, 32'h77, w);
        do_push(2'd2, 5'd2, 5'd0, 5'd5, 1'b0, 32'd0, 32'h2222, 32'hBEEF, 32'h2222, 32'd0, w);
        chk("rd0_no_pend", w, 0);
        idle(3);

        // 6: reset with FULL FIFO and pending bits
        out_ready = 1'b0;
        do_push(2'd0, 5'd1, 5'd2, 5'd6, 1'b0, 32'd0, 32'd1, 32'd2, 32'd1, 32'd2, w);
        do_push(2'd0, 5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 32'd3, 32'd4, 32'd3, 32'd4, w);
        reset = 1'b1; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("in_ready_in_reset", {71'd0, in_ready}, 72'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_in(2'd2, 5'd6, 5'd7, 5'd4, 1'b0, 32'd0, 32'h61, 32'h71);
        in_valid = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", {71'd0, out_valid}, 72'd0);
        chk("post_reset_fields", {out_op, out_in1, out_in2, out_rd}, 72'd0);
        chk("post_reset_pend_clear", {71'd0, in_ready}, 72'd1);
        q.push_back('{op: 2'd2, in1: 32'h61, in2: 32'h71, rd: 5'd4});
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;

        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
